// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the instruction loader and the processor around it.
//   state_t        : 2-bit loader FSM encoding
//   MAX_WORDS_DEF  : default maximum program length in words
//   CNT_W_DEF      : default width of length/count fields
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam int MAX_WORDS_DEF = 256;
    localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/instr_loader.sv
// instr_loader
// Boot-time loader: copies a program from a valid/ready word source into
// instruction memory, then releases the PC and lets the processor run.
//
// Ports
//   clk, reset_n        : clock (rising edge), async active-low reset
//   start, progLength   : load request and program length (words)
//   wordIn, wordValid   : source word stream
//   wordReady           : loader accepts wordIn this cycle
//   instrAddr/instrIn   : instruction-memory byte address / write data
//   instrWrite/instrRead: instruction-memory write / read enables
//   pcReset, pcWrite    : PC register reset / update enable
//   initializing        : steers loader address into the imem address mux
//   done                : processor released and running
//   loadCount           : words written so far
//   lenErr              : sticky, last start rejected for excessive length
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; PC held in reset
//   LOAD    | accepting words, one imem write per handshake
//   RELEASE | one cycle: imem switched to fetch, PC still in reset
//   RUN     | processor running; terminal until reset
module instr_loader
    import mips_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] progLength,
    input  logic [31:0]      wordIn,
    input  logic             wordValid,
    output logic             wordReady,
    output logic [31:0]      instrAddr,
    output logic [31:0]      instrIn,
    output logic             instrWrite,
    output logic             instrRead,
    output logic             pcReset,
    output logic             pcWrite,
    output logic             initializing,
    output logic             done,
    output logic [CNT_W-1:0] loadCount,
    output logic             lenErr
);

    // One extra bit so the length check also works when MAX_WORDS == 2**CNT_W.
    localparam logic [32:0] MAX_LEN = 33'(MAX_WORDS);

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_count;
    logic             r_len_err;

    logic w_in_load;
    logic w_handshake;
    logic w_last;
    logic w_len_zero;
    logic w_len_over;

    assign w_in_load   = (r_state == ST_LOAD);
    assign w_handshake = wordValid & w_in_load;
    // r_len is at least 1 whenever LOAD is entered, so no underflow here.
    assign w_last      = (r_count == (r_len - CNT_W'(1)));
    assign w_len_zero  = (progLength == '0);
    assign w_len_over  = (33'(progLength) > MAX_LEN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_len_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_len_over) begin
                            r_len_err <= 1'b1;
                        end else begin
                            r_len_err <= 1'b0;
                            r_len     <= progLength;
                            r_count   <= '0;
                            r_state   <= w_len_zero ? ST_RELEASE : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Count advances on the same edge that memory captures the word.
                    if (w_handshake) begin
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode from the state register; only the write strobe looks at wordValid.
    assign wordReady    = w_in_load;
    assign instrWrite   = w_handshake;
    assign instrIn      = wordIn;
    assign instrAddr    = w_in_load ? 32'({r_count, 2'b00}) : 32'd0;
    assign initializing = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign pcReset      = (r_state != ST_RUN);
    assign instrRead    = (r_state == ST_RELEASE) || (r_state == ST_RUN);
    assign pcWrite      = (r_state == ST_RUN);
    assign done         = (r_state == ST_RUN);
    assign loadCount    = r_count;
    assign lenErr       = r_len_err;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int MAXW = 8;
    localparam int CW   = 8;

    // {initializing, pcReset, wordReady, instrRead, pcWrite, done}
    localparam logic [5:0] O_IDLE = 6'b110000;
    localparam logic [5:0] O_LOAD = 6'b111000;
    localparam logic [5:0] O_REL  = 6'b010100;
    localparam logic [5:0] O_RUN  = 6'b000111;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] progLength;
    logic [31:0]   wordIn;
    logic          wordValid;
    logic          wordReady;
    logic [31:0]   instrAddr;
    logic [31:0]   instrIn;
    logic          instrWrite;
    logic          instrRead;
    logic          pcReset;
    logic          pcWrite;
    logic          initializing;
    logic          done;
    logic [CW-1:0] loadCount;
    logic          lenErr;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb[$];   // expected writes {addr, data}

    instr_loader #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .progLength(progLength),
        .wordIn(wordIn), .wordValid(wordValid), .wordReady(wordReady),
        .instrAddr(instrAddr), .instrIn(instrIn), .instrWrite(instrWrite),
        .instrRead(instrRead), .pcReset(pcReset), .pcWrite(pcWrite),
        .initializing(initializing), .done(done), .loadCount(loadCount),
        .lenErr(lenErr)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {initializing, pcReset, wordReady, instrRead, pcWrite, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_state(input string tag, input logic [5:0] o, input int cnt);
        check({tag, "_outs"}, 32'(outs()), 32'(o));
        check({tag, "_cnt"}, 32'(loadCount), 32'(cnt));
        if (o != O_LOAD) check({tag, "_addr0"}, instrAddr, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; wordValid = 1'b0;
        #2;
        // still mid-cycle: reset must act without a clock edge
        check("async_rst_outs", 32'(outs()), 32'(O_IDLE));
        check("async_rst_cnt", 32'(loadCount), 32'd0);
        check("async_rst_lenerr", 32'(lenErr), 32'd0);
        check("async_rst_addr", instrAddr, 32'd0);
        check("async_rst_wr", 32'(instrWrite), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Issue start; return one cycle later with the FSM past the accepting edge.
    task automatic do_start(input int len);
        start = 1'b1;
        progLength = CW'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic offer(input logic v, input logic [31:0] d, input int addr);
        wordValid = v;
        wordIn = d;
        if (v) sb.push_back({32'(addr), d});
    endtask

    // Write monitor: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (instrWrite === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", instrAddr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("wr_addr", instrAddr, e[63:32]);
                check("wr_data", instrIn, e[31:0]);
                check("wr_ready", 32'(wordReady), 32'd1);
            end
        end
    end

    initial begin
        logic [4:0] pat;
        int k;
        reset_n = 1'b0; start = 1'b0; progLength = '0;
        wordIn = 32'hDEAD_BEEF; wordValid = 1'b0;
        #1;
        do_reset();

        // Basic two-word load, back-to-back.
        sample();
        expect_state("idle", O_IDLE, 0);
        check("idle_lenerr", 32'(lenErr), 32'd0);
        do_start(2);
        offer(1'b1, 32'h2010_0002, 0);
        sample();
        expect_state("load0", O_LOAD, 0);
        check("load0_addr", instrAddr, 32'd0);
        tick();
        offer(1'b1, 32'h2210_0003, 4);
        sample();
        expect_state("load1", O_LOAD, 1);
        tick();
        offer(1'b0, 32'h0, 0);
        sample();
        expect_state("release", O_REL, 2);
        tick();
        sample();
        expect_state("run", O_RUN, 2);
        // start in RUN is ignored
        do_start(3);
        sample();
        expect_state("run_start", O_RUN, 2);
        tick();
        sample();
        expect_state("run_hold", O_RUN, 2);
        check("sb_empty_1", 32'(sb.size()), 32'd0);

        // Three words with gaps in wordValid.
        do_reset();
        do_start(3);
        pat = 5'b10101;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            offer(pat[4-i], 32'hA000_0000 + 32'(i), 4 * k);
            sample();
            expect_state("gap_load", O_LOAD, k);
            check("gap_wr", 32'(instrWrite), 32'(pat[4-i]));
            if (pat[4-i]) k++;
            tick();
        end
        offer(1'b0, 32'h0, 0);
        sample();
        expect_state("gap_release", O_REL, 3);
        check("sb_empty_2", 32'(sb.size()), 32'd0);

        // Zero-length program: straight to RELEASE, no writes even with valid high.
        do_reset();
        wordValid = 1'b1;
        do_start(0);
        sample();
        expect_state("zero_release", O_REL, 0);
        check("zero_wr", 32'(instrWrite), 32'd0);
        tick();
        sample();
        expect_state("zero_run", O_RUN, 0);
        wordValid = 1'b0;

        // Over-length start rejected, then a one-word load clears lenErr.
        do_reset();
        do_start(MAXW + 1);
        sample();
        expect_state("over_idle", O_IDLE, 0);
        check("over_lenerr", 32'(lenErr), 32'd1);
        tick();
        sample();
        check("over_lenerr_sticky", 32'(lenErr), 32'd1);
        do_start(1);
        offer(1'b1, 32'h1234_5678, 0);
        sample();
        expect_state("one_load", O_LOAD, 0);
        check("one_lenerr_clr", 32'(lenErr), 32'd0);
        tick();
        offer(1'b0, 32'h0, 0);
        sample();
        expect_state("one_release", O_REL, 1);

        // Reset mid-load, then reload four words from address 0.
        do_reset();
        do_start(4);
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 32'hB000_0000 + 32'(i), 4 * i);
            tick();
        end
        offer(1'b0, 32'h0, 0);
        sample();
        expect_state("mid_load", O_LOAD, 2);
        tick();
        do_reset();
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'hC000_0000 + 32'(i), 4 * i);
            sample();
            expect_state("reload", O_LOAD, i);
            tick();
        end
        offer(1'b0, 32'h0, 0);
        sample();
        expect_state("reload_release", O_REL, 4);

        // Maximum length accepted, last address 4*(MAXW-1).
        do_reset();
        do_start(MAXW);
        for (int i = 0; i < MAXW; i++) begin
            offer(1'b1, 32'hD000_0000 + 32'(i), 4 * i);
            tick();
        end
        offer(1'b1, 32'hEEEE_EEEE, 0);
        sb.delete(sb.size() - 1);
        sample();
        expect_state("max_release", O_REL, MAXW);
        check("max_lenerr", 32'(lenErr), 32'd0);
        tick();
        sample();
        expect_state("max_run", O_RUN, MAXW);
        wordValid = 1'b0;
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
